// File: rtl/pow_5_pkg.sv
// Shared definitions for the round-robin x^5 scheduler: state encoding,
// multiply count and the requester-id width helper.
package pow_5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int MUL_COUNT = 4;

    // Width of an index into n entries, never less than one bit.
    function automatic int calc_id_w(input int n);
        for (int r = 1; r < 32; r++) begin
            if ((1 << r) >= n) return r;
        end
        return 32;
    endfunction

endpackage

// File: rtl/pow_5_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// searching upward from last_grant+1, wrapping modulo n_req.
module rr_arbiter
    import pow_5_pkg::*;
#(
    parameter int n_req = 4,
    localparam int id_w = calc_id_w(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [id_w-1:0]  last_grant,
    input  logic             en,
    output logic [n_req-1:0] gnt,
    output logic [id_w-1:0]  gnt_idx,
    output logic             any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= n_req; k++) begin
            if (en && !any && req[(int'(last_grant) + k) % n_req]) begin
                any = 1'b1;
                gnt[(int'(last_grant) + k) % n_req] = 1'b1;
                gnt_idx = id_w'((int'(last_grant) + k) % n_req);
            end
        end
    end

endmodule

// File: rtl/pow_5_rr_scheduler.sv
// Shares one x^5 engine between n_req requesters; a granted argument is
// multiplied into itself four times and returned tagged with its requester id.
module pow_5_rr_scheduler
    import pow_5_pkg::*;
#(
    parameter int w     = 8,
    parameter int n_req = 4,
    localparam int id_w = calc_id_w(n_req)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [n_req-1:0]   req_vld,
    input  logic [n_req*w-1:0] req_arg,
    output logic [n_req-1:0]   req_rdy,
    output logic               res_vld,
    output logic [id_w-1:0]    res_id,
    output logic [w-1:0]       res,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Handshake: requester i transfers when req_vld[i] && req_rdy[i] at a rising
    // edge; req_rdy is one-hot or zero and only asserted in IDLE.

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [w-1:0]    arg_q, arg_d;
    logic [w-1:0]    mul_q, mul_d;
    logic [id_w-1:0] id_q, id_d;
    logic [id_w-1:0] last_grant_q, last_grant_d;
    logic            res_vld_q, res_vld_d;
    logic [w-1:0]    res_q, res_d;
    logic [id_w-1:0] res_id_q, res_id_d;

    logic [id_w-1:0] gnt_idx;
    logic            gnt_any;
    logic [w-1:0]    sel_arg;

    rr_arbiter #(.n_req(n_req)) u_arb (
        .req        (req_vld),
        .last_grant (last_grant_q),
        .en         ((state_q == ST_IDLE) && rst_n),
        .gnt        (req_rdy),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign sel_arg = req_arg[int'(gnt_idx)*w +: w];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        arg_d        = arg_q;
        mul_d        = mul_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        res_vld_d    = 1'b0;
        res_d        = res_q;
        res_id_d     = res_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    arg_d        = sel_arg;
                    mul_d        = sel_arg;
                    id_d         = gnt_idx;
                    last_grant_d = gnt_idx;
                    cnt_d        = 2'd0;
                    state_d      = ST_MUL;
                end
            end
            ST_MUL: begin
                mul_d = mul_q * arg_q;
                cnt_d = cnt_q + 2'd1;
                // Result registers load on the last multiply so RESP drives flops.
                if (cnt_q == 2'(MUL_COUNT - 1)) begin
                    state_d   = ST_RESP;
                    res_vld_d = 1'b1;
                    res_d     = mul_q * arg_q;
                    res_id_d  = id_q;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            arg_q        <= '0;
            mul_q        <= '0;
            id_q         <= '0;
            last_grant_q <= id_w'(n_req - 1);
            res_vld_q    <= 1'b0;
            res_q        <= '0;
            res_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            arg_q        <= arg_d;
            mul_q        <= mul_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            res_vld_q    <= res_vld_d;
            res_q        <= res_d;
            res_id_q     <= res_id_d;
        end
    end

    assign res_vld   = res_vld_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule
